at86rf215_rx_capture_ctrl: RTL and testbench

Capture sequencer between the AT86RF215 I/Q RX deserializer's AXI-Stream output and the downstream DMA/stream sink. On a software start it waits for the deserializer's `in_sync`, then gates a programmed number of fixed-length packets through with `tlast` framing. It zero-pads partial packets on sync loss or abort, flushes the upstream stream while idle, and reports timeout, sync-loss, abort and overflow status.

---
 rtl/at86rf215_rx_capture_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_at86rf215_rx_capture_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/at86rf215_rx_capture_ctrl.sv
// -----------------------------------------------------------------------------
// at86rf215_rx_capture_ctrl
//
// Capture sequencer that sits between the AT86RF215 I/Q RX deserializer's
// AXI-Stream output and a downstream DMA/stream sink.
//
// A software start arms the block. It then waits for the deserializer to
// report in_sync and gates a programmed number of fixed-length packets
// downstream, framing each packet with tlast. A partial packet that is cut
// short by sync loss or abort is completed with zero words, so the sink
// always sees whole packets. While the block is not capturing, the upstream
// stream is drained and discarded so the deserializer FIFO never stalls.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   start                  one-cycle capture request (honoured only when idle)
//   abort                  terminates the current capture
//   packet_len             words per packet, latched at start (0 = start ignored)
//   num_packets            packets per capture, latched at start (0 = unbounded)
//   timeout_cycles         sync wait limit, latched at start (0 = no limit)
//   in_sync                deserializer sync indication
//   rx_overflow            deserializer FIFO overflow strobe
//   s_axis_*               upstream stream (tvalid/tdata in, tready out)
//   m_axis_*               downstream stream (tvalid/tdata/tlast out, tready in)
//   busy                   high whenever the sequencer is not idle
//   done                   one-cycle pulse when a capture ends
//   status                 sticky {aborted, sync_lost, timeout}
//   overflow_count         saturating count of rx_overflow cycles while busy
//   packet_count           packets completed (tlast beats) in this capture
//
// Handshake: a transfer (beat) happens on a cycle where tvalid and tready
// are both high at the rising clock edge. m_axis_tvalid never depends on
// m_axis_tready. Once m_axis_tvalid is high with m_axis_tready low, data and
// tlast hold until the beat; only abort or sync loss may withdraw tvalid.
// -----------------------------------------------------------------------------
module at86rf215_rx_capture_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TMO_WIDTH  = 24
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  packet_len,
  input  logic [LEN_WIDTH-1:0]  num_packets,
  input  logic [TMO_WIDTH-1:0]  timeout_cycles,
  input  logic                  in_sync,
  input  logic                  rx_overflow,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            status,
  output logic [15:0]           overflow_count,
  output logic [LEN_WIDTH-1:0]  packet_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_PAD       = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);
  localparam logic [15:0]          OVF_MAX = 16'hFFFF;

  // status bit positions
  localparam int ST_BIT_TIMEOUT = 0;
  localparam int ST_BIT_SYNCLOST = 1;
  localparam int ST_BIT_ABORTED = 2;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   num_q, num_d;
  logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
  logic [TMO_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [LEN_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [2:0]             status_q, status_d;
  logic [15:0]            ovf_cnt_q, ovf_cnt_d;

  // Word position / terminal-count decodes shared by CAPTURE and PAD.
  logic last_word;
  logic last_packet;
  logic tmo_hit;

  assign last_word   = (word_cnt_q == (len_q - LEN_ONE));
  // num_q == 0 means an unbounded capture, so it never hits the last packet.
  assign last_packet = (num_q != '0) && (pkt_cnt_q == (num_q - LEN_ONE));
  assign tmo_hit     = (tmo_q != '0) && (tmo_cnt_q == (tmo_q - TMO_ONE));

  // ---------------------------------------------------------------------------
  // Next-state, datapath steering and counter updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    num_d      = num_q;
    tmo_d      = tmo_q;
    tmo_cnt_d  = tmo_cnt_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    status_d   = status_q;
    ovf_cnt_d  = ovf_cnt_q;

    // Idle-style stream: upstream drained, nothing offered downstream.
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (packet_len != '0)) begin
          len_d      = packet_len;
          num_d      = num_packets;
          tmo_d      = timeout_cycles;
          tmo_cnt_d  = '0;
          word_cnt_d = '0;
          pkt_cnt_d  = '0;
          status_d   = '0;
          ovf_cnt_d  = '0;
          state_d    = ST_WAIT_SYNC;
        end
      end

      ST_WAIT_SYNC: begin
        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        if (abort) begin
          status_d[ST_BIT_ABORTED] = 1'b1;
          state_d                  = ST_FINISH;
        end else if (in_sync) begin
          word_cnt_d = '0;
          state_d    = ST_CAPTURE;
        end else if (tmo_hit) begin
          status_d[ST_BIT_TIMEOUT] = 1'b1;
          state_d                  = ST_FINISH;
        end
      end

      ST_CAPTURE: begin
        if (in_sync && !abort) begin
          // Zero-latency pass-through; tlast is purely a function of the
          // registered word position, so it is stable under backpressure.
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tlast  = last_word;
          s_axis_tready = m_axis_tready;
          if (s_axis_tvalid && m_axis_tready) begin
            if (last_word) begin
              word_cnt_d = '0;
              pkt_cnt_d  = pkt_cnt_q + LEN_ONE;
              if (last_packet) begin
                state_d = ST_FINISH;
              end
            end else begin
              word_cnt_d = word_cnt_q + LEN_ONE;
            end
          end
        end else begin
          // Sync loss and abort are both recorded when they coincide. A
          // packet already under way is closed out with zero words.
          if (!in_sync) begin
            status_d[ST_BIT_SYNCLOST] = 1'b1;
          end
          if (abort) begin
            status_d[ST_BIT_ABORTED] = 1'b1;
          end
          state_d = (word_cnt_q != '0) ? ST_PAD : ST_FINISH;
        end
      end

      ST_PAD: begin
        // abort and in_sync are deliberately ignored until the packet closes.
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = last_word;
        if (m_axis_tready) begin
          if (last_word) begin
            word_cnt_d = '0;
            pkt_cnt_d  = pkt_cnt_q + LEN_ONE;
            state_d    = ST_FINISH;
          end else begin
            word_cnt_d = word_cnt_q + LEN_ONE;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Overflow strobes are counted in every non-idle state. The clear on an
    // accepted start only happens in IDLE, so the two never collide.
    if ((state_q != ST_IDLE) && rx_overflow && (ovf_cnt_q != OVF_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      num_q      <= '0;
      tmo_q      <= '0;
      tmo_cnt_q  <= '0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      status_q   <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      num_q      <= num_d;
      tmo_q      <= tmo_d;
      tmo_cnt_q  <= tmo_cnt_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      status_q   <= status_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_FINISH);
  assign status         = status_q;
  assign overflow_count = ovf_cnt_q;
  assign packet_count   = pkt_cnt_q;

endmodule

// File: tb/tb_at86rf215_rx_capture_ctrl.sv
module tb_at86rf215_rx_capture_ctrl;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int TW = 24;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] packet_len = '0;
  logic [LW-1:0] num_packets = '0;
  logic [TW-1:0] timeout_cycles = '0;
  logic          in_sync = 1'b0;
  logic          rx_overflow = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b0;
  logic          busy;
  logic          done;
  logic [2:0]    status;
  logic [15:0]   overflow_count;
  logic [LW-1:0] packet_count;

  always #5 aclk = ~aclk;

  at86rf215_rx_capture_ctrl #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .TMO_WIDTH  (TW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start          (start),
    .abort          (abort),
    .packet_len     (packet_len),
    .num_packets    (num_packets),
    .timeout_cycles (timeout_cycles),
    .in_sync        (in_sync),
    .rx_overflow    (rx_overflow),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .busy           (busy),
    .done           (done),
    .status         (status),
    .overflow_count (overflow_count),
    .packet_count   (packet_count)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic          up_hs = 1'b0;      // upstream handshake seen in last cycle
  logic [DW:0]   exp_q[$];          // {tlast, data} expected downstream beats
  logic [DW:0]   obs_q[$];          // {tlast, data} observed downstream beats
  int            done_cnt, done_cyc, start_cyc, abort_cyc, last_beat_cyc;
  int            mvalid_cnt;

  // Behavioural reference: capture phase plus plain counters.
  string         ph = "idle";
  logic [LW-1:0] e_len, e_num, e_pk, e_wc;
  logic [TW-1:0] e_tmo, e_wait;
  logic [2:0]    e_st;
  logic [15:0]   e_ovf;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    start_cyc     = -1;
    abort_cyc     = -1;
    last_beat_cyc = -1;
    mvalid_cnt    = 0;
  endtask

  task automatic exp_words(input int first, input int last, input int len);
    for (int i = first; i <= last; i++) begin
      exp_q.push_back({((i - first + 1) % len) == 0, DW'(i)});
    end
  endtask

  task automatic check_stream(input string name);
    chk({name, "_beats"}, 40'(obs_q.size()), 40'(exp_q.size()));
    if (obs_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) chk({name, "_word"}, 40'(obs_q[i]), 40'(exp_q[i]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every cycle, at the falling edge
  // ---------------------------------------------------------------------------
  initial begin : cmp
    logic          x_sr, x_mv, x_ml, pass, x_beat;
    logic [DW-1:0] x_md;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        chk("rst_busy",  40'(busy), 40'(0));
        chk("rst_done",  40'(done), 40'(0));
        chk("rst_status", 40'(status), 40'(0));
        chk("rst_ovf",   40'(overflow_count), 40'(0));
        chk("rst_pkt",   40'(packet_count), 40'(0));
        chk("rst_mvalid", 40'(m_axis_tvalid), 40'(0));
        chk("rst_mlast", 40'(m_axis_tlast), 40'(0));
        chk("rst_mdata", 40'(m_axis_tdata), 40'(0));
        chk("rst_sready", 40'(s_axis_tready), 40'(1));
        ph = "idle"; e_len = '0; e_num = '0; e_pk = '0; e_wc = '0;
        e_tmo = '0; e_wait = '0; e_st = '0; e_ovf = '0;
        up_hs = 1'b0;
      end else begin
        // expected outputs for this cycle
        x_sr = 1'b1; x_mv = 1'b0; x_md = '0; x_ml = 1'b0;
        pass = in_sync && !abort;
        if (ph == "cap" && pass) begin
          x_mv = s_axis_tvalid;
          x_md = s_axis_tdata;
          x_ml = (int'(e_wc) == int'(e_len) - 1);
          x_sr = m_axis_tready;
        end else if (ph == "pad") begin
          x_mv = 1'b1;
          x_ml = (int'(e_wc) == int'(e_len) - 1);
        end
        chk("busy",   40'(busy), 40'(ph != "idle"));
        chk("done",   40'(done), 40'(ph == "fin"));
        chk("s_tready", 40'(s_axis_tready), 40'(x_sr));
        chk("m_tvalid", 40'(m_axis_tvalid), 40'(x_mv));
        chk("status", 40'(status), 40'(e_st));
        chk("overflow_count", 40'(overflow_count), 40'(e_ovf));
        chk("packet_count", 40'(packet_count), 40'(e_pk));
        if (x_mv) begin
          chk("m_tdata", 40'(m_axis_tdata), 40'(x_md));
          chk("m_tlast", 40'(m_axis_tlast), 40'(x_ml));
        end
        x_beat = x_mv && m_axis_tready;

        // observation for directed checks and the stimulus driver
        up_hs = s_axis_tvalid && s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
          obs_q.push_back({m_axis_tlast, m_axis_tdata});
          last_beat_cyc = cyc;
        end
        if (m_axis_tvalid) mvalid_cnt++;
        if (done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (start && start_cyc < 0) start_cyc = cyc;
        if (abort && abort_cyc < 0) abort_cyc = cyc;

        // advance the reference
        if (ph != "idle" && rx_overflow && e_ovf != 16'hFFFF) e_ovf++;
        if (ph == "idle") begin
          if (start && packet_len != '0) begin
            e_len = packet_len; e_num = num_packets; e_tmo = timeout_cycles;
            e_st = '0; e_ovf = '0; e_pk = '0; e_wc = '0; e_wait = '0;
            ph = "wait";
          end
        end else if (ph == "wait") begin
          if (abort) begin
            e_st[2] = 1'b1; ph = "fin";
          end else if (in_sync) begin
            e_wc = '0; ph = "cap";
          end else if (e_tmo != '0 && int'(e_wait) == int'(e_tmo) - 1) begin
            e_st[0] = 1'b1; ph = "fin";
          end
          e_wait++;
        end else if (ph == "cap") begin
          if (pass) begin
            if (x_beat) begin
              if (int'(e_wc) == int'(e_len) - 1) begin
                e_wc = '0;
                e_pk++;
                if (e_num != '0 && e_pk == e_num) ph = "fin";
              end else begin
                e_wc++;
              end
            end
          end else begin
            if (!in_sync) e_st[1] = 1'b1;
            if (abort) e_st[2] = 1'b1;
            ph = (e_wc != '0) ? "pad" : "fin";
          end
        end else if (ph == "pad") begin
          if (m_axis_tready) begin
            if (int'(e_wc) == int'(e_len) - 1) begin
              e_wc = '0; e_pk++; ph = "fin";
            end else begin
              e_wc++;
            end
          end
        end else begin
          ph = "idle";
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_start(input int len, input int num, input int tmo);
    packet_len     = LW'(len);
    num_packets    = LW'(num);
    timeout_cycles = TW'(tmo);
    start = 1'b1;
    tick();
    start = 1'b0;
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  // Feeds words 1..nw upstream; mode 0: tready=1, 1: toggling, 2: random.
  task automatic stream(input int nw, input int maxc, input int mode, input int drop_at,
                        input int abort_at, input int stop_at, input bit ovf);
    int w;
    bit ab_done;
    w = 1;
    ab_done = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      if (stop_at != 0 && w > stop_at) break;
      s_axis_tvalid = (w <= nw);
      s_axis_tdata  = DW'(w);
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (c % 2 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      if (drop_at != 0 && w > drop_at) in_sync = 1'b0;
      abort = 1'b0;
      if (abort_at != 0 && w > abort_at && !ab_done) begin
        abort = 1'b1;
        ab_done = 1'b1;
      end
      rx_overflow = ovf && c >= 1 && c <= 3;
      tick();
      if (up_hs) w++;
    end
    abort = 1'b0;
    rx_overflow = 1'b0;
    s_axis_tvalid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : main
    clear_obs();
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // nominal capture
    clear_obs();
    in_sync = 1'b1; m_axis_tready = 1'b1;
    do_start(4, 2, 0);
    stream(8, 20, 0, 0, 0, 0, 1'b0);
    exp_words(1, 8, 4);
    check_stream("nominal");
    chk("nominal_done_cnt", 40'(done_cnt), 40'(1));
    chk("nominal_done_gap", 40'(done_cyc - last_beat_cyc), 40'(1));
    chk("nominal_status", 40'(status), 40'(3'b000));
    chk("nominal_pkt", 40'(packet_count), 40'(2));

    // backpressure
    clear_obs();
    do_start(4, 2, 0);
    stream(8, 40, 1, 0, 0, 0, 1'b0);
    exp_words(1, 8, 4);
    check_stream("backpressure");
    chk("bp_pkt", 40'(packet_count), 40'(2));
    chk("bp_done_cnt", 40'(done_cnt), 40'(1));

    // zero length start is ignored
    clear_obs();
    do_start(0, 1, 0);
    repeat (3) tick();
    chk("len0_busy", 40'(busy), 40'(0));
    chk("len0_done_cnt", 40'(done_cnt), 40'(0));

    // timeout
    clear_obs();
    in_sync = 1'b0;
    do_start(4, 2, 10);
    s_axis_tvalid = 1'b1;
    repeat (15) tick();
    s_axis_tvalid = 1'b0;
    chk("tmo_done_delay", 40'(done_cyc - start_cyc), 40'(11));
    chk("tmo_status", 40'(status), 40'(3'b001));
    chk("tmo_no_mvalid", 40'(mvalid_cnt), 40'(0));

    // sync loss mid-packet
    clear_obs();
    in_sync = 1'b1;
    do_start(4, 0, 0);
    stream(8, 20, 0, 2, 0, 0, 1'b0);
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b0, 32'd2});
    exp_q.push_back({1'b0, 32'd0});
    exp_q.push_back({1'b1, 32'd0});
    check_stream("syncloss");
    chk("syncloss_status", 40'(status), 40'(3'b010));
    chk("syncloss_pkt", 40'(packet_count), 40'(1));
    chk("syncloss_done_cnt", 40'(done_cnt), 40'(1));

    // abort on a packet boundary
    clear_obs();
    in_sync = 1'b1;
    do_start(4, 0, 0);
    stream(8, 20, 0, 0, 8, 0, 1'b0);
    exp_words(1, 8, 4);
    check_stream("abort");
    chk("abort_status", 40'(status), 40'(3'b100));
    chk("abort_pkt", 40'(packet_count), 40'(2));
    chk("abort_done_gap", 40'(done_cyc - abort_cyc), 40'(1));

    // overflow counting then reset mid-packet
    clear_obs();
    do_start(4, 0, 0);
    stream(8, 30, 0, 0, 0, 5, 1'b1);
    chk("ovf_count", 40'(overflow_count), 40'(3));
    chk("ovf_pkt", 40'(packet_count), 40'(1));
    clear_obs();
    aresetn = 1'b0;
    #1;
    chk("arst_busy", 40'(busy), 40'(0));
    chk("arst_sready", 40'(s_axis_tready), 40'(1));
    chk("arst_mvalid", 40'(m_axis_tvalid), 40'(0));
    chk("arst_ovf", 40'(overflow_count), 40'(0));
    chk("arst_pkt", 40'(packet_count), 40'(0));
    tick();
    tick();
    aresetn = 1'b1;
    repeat (4) tick();
    chk("arst_no_done", 40'(done_cnt), 40'(0));
    chk("arst_no_pad", 40'(obs_q.size()), 40'(0));

    // randomized captures against the reference
    for (int r = 0; r < 30; r++) begin
      in_sync = 1'b0;
      abort = 1'b0;
      do_start((r % 5 == 0) ? 0 : int'($urandom_range(1, 5)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0);
      for (int c = 0; c < 60; c++) begin
        in_sync       = (c >= 2) && ($urandom_range(0, 24) != 0);
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tdata  = $urandom;
        m_axis_tready = ($urandom_range(0, 3) != 0);
        abort         = ($urandom_range(0, 49) == 0) || (c == 55);
        rx_overflow   = ($urandom_range(0, 5) == 0);
        start         = ($urandom_range(0, 29) == 0);
        tick();
      end
      start = 1'b0; rx_overflow = 1'b0; in_sync = 1'b0;
      m_axis_tready = 1'b1; s_axis_tvalid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (8) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
